// File: rtl/arm7tdmi_mmu.sv
// MMU for the ARM7TDMI data port. It has a fully-associative, ASID-tagged TLB, an ARMv4
// section/coarse-page table walker, domain/AP permission checking and statistics counters.
module arm7tdmi_mmu #(
  parameter int TLB_ENTRIES = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_vaddr,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [1:0]            cpu_size,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_abort,
  output logic [ADDR_WIDTH-1:0] mem_paddr,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [1:0]            mem_size,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  input  logic                  mem_abort,
  input  logic [31:0]           ttb_base,
  input  logic                  mmu_enable,
  input  logic                  cache_enable,
  input  logic [3:0]            domain_access,
  input  logic [7:0]            current_asid,
  input  logic                  tlb_flush_all,
  input  logic                  tlb_flush_entry,
  input  logic [31:0]           tlb_flush_addr,
  input  logic                  tlb_flush_asid,
  input  logic [7:0]            tlb_flush_asid_val,
  input  logic                  tlb_flush_global,
  output logic [31:0]           tlb_hits,
  output logic [31:0]           tlb_misses,
  output logic [31:0]           page_faults,
  output logic [31:0]           asid_switches,
  output logic                  mmu_busy
);
  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TLB_LOOKUP = 3'd1,
    L1_FETCH   = 3'd2,
    L2_FETCH   = 3'd3,
    MEM_ACCESS = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] r_va, r_pa, r_paddr_hold;
  logic                  r_write;
  logic [1:0]            r_size;
  logic [31:0]           r_wdata;
  logic                  r_phase;
  logic [31:0]           r_l1_addr, r_l1_pte, r_l2_addr, r_l2_pte;
  logic [31:0]           r_cpu_rdata;
  logic                  r_cpu_ready, r_cpu_abort;
  logic [31:0]           r_hits, r_misses, r_faults, r_asid_sw;
  logic [7:0]            r_prev_asid;
  logic [IDX_W-1:0]      r_rr;

  logic                  r_tlb_valid  [TLB_ENTRIES];
  logic                  r_tlb_global [TLB_ENTRIES];
  logic                  r_tlb_sec    [TLB_ENTRIES];
  logic [7:0]            r_tlb_asid   [TLB_ENTRIES];
  logic [19:0]           r_tlb_tag    [TLB_ENTRIES];
  logic [19:0]           r_tlb_pbase  [TLB_ENTRIES];
  logic                  r_tlb_dom    [TLB_ENTRIES];
  logic [1:0]            r_tlb_ap     [TLB_ENTRIES];

  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic [TLB_ENTRIES-1:0] w_kill;
  logic                  w_any_flush, w_fill_ok;
  logic                  w_phase_next, w_mem_req, w_mem_write;
  logic [1:0]            w_mem_size;
  logic [ADDR_WIDTH-1:0] w_mem_addr, w_next_pa;
  logic [31:0]           w_l1_addr, w_l2_addr;
  logic                  w_load_pa, w_fill, w_fill_sec, w_fill_dom;
  logic [1:0]            w_fill_ap;
  logic                  w_fault, w_cnt_hit, w_cnt_miss, w_acc_done, w_l1_cap, w_l2_cap;
  logic                  w_unused;

  // Only domains 0..1 exist, so bit 0 of the descriptor domain selects the DACR pair.
  function automatic logic perm_fault(input logic dom, input logic [1:0] ap,
                                      input logic wr, input logic [3:0] dacr);
    logic [1:0] acc;
    acc = dom ? dacr[3:2] : dacr[1:0];
    case (acc)
      2'b11:   return 1'b0;
      2'b01:   return (ap == 2'b00) || ((ap == 2'b10) && wr);
      default: return 1'b1;
    endcase
  endfunction

  assign w_l1_addr = {ttb_base[31:14], r_va[31:20], 2'b00};
  assign w_l2_addr = {r_l1_pte[31:10], r_va[19:12], 2'b00};

  // First matching entry wins; section entries ignore the low 8 tag bits.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (!w_hit && r_tlb_valid[i] &&
          (r_tlb_global[i] || (r_tlb_asid[i] == current_asid)) &&
          (r_tlb_tag[i][19:8] == r_va[31:20]) &&
          (r_tlb_sec[i] || (r_tlb_tag[i][7:0] == r_va[19:12]))) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_kill = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      w_kill[i] = tlb_flush_all ||
                  (tlb_flush_entry && (r_tlb_tag[i][19:8] == tlb_flush_addr[31:20]) &&
                   (r_tlb_sec[i] || (r_tlb_tag[i][7:0] == tlb_flush_addr[19:12]))) ||
                  (tlb_flush_asid && !r_tlb_global[i] && (r_tlb_asid[i] == tlb_flush_asid_val)) ||
                  (tlb_flush_global && r_tlb_global[i]);
    end
  end

  assign w_any_flush = tlb_flush_all | tlb_flush_entry | tlb_flush_asid | tlb_flush_global;
  assign w_fill_ok   = w_fill & ~w_any_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    w_phase_next = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_size   = 2'b10;
    w_mem_addr   = r_pa;
    w_load_pa    = 1'b0;
    w_next_pa    = r_pa;
    w_fill       = 1'b0;
    w_fill_sec   = 1'b0;
    w_fill_dom   = 1'b0;
    w_fill_ap    = 2'b00;
    w_fault      = 1'b0;
    w_cnt_hit    = 1'b0;
    w_cnt_miss   = 1'b0;
    w_acc_done   = 1'b0;
    w_l1_cap     = 1'b0;
    w_l2_cap     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          w_load_pa  = 1'b1;
          w_next_pa  = cpu_vaddr;
          next_state = mmu_enable ? TLB_LOOKUP : MEM_ACCESS;
        end
      end
      TLB_LOOKUP: begin
        if (w_hit) begin
          w_cnt_hit = 1'b1;
          if (perm_fault(r_tlb_dom[w_hit_idx], r_tlb_ap[w_hit_idx], r_write, domain_access)) begin
            w_fault    = 1'b1;
            next_state = DONE;
          end else begin
            w_load_pa  = 1'b1;
            w_next_pa  = r_tlb_sec[w_hit_idx] ? {r_tlb_pbase[w_hit_idx][19:8], r_va[19:0]}
                                              : {r_tlb_pbase[w_hit_idx], r_va[11:0]};
            next_state = MEM_ACCESS;
          end
        end else begin
          w_cnt_miss = 1'b1;
          next_state = L1_FETCH;
        end
      end
      L1_FETCH: begin
        w_mem_addr = w_l1_addr;
        if (!r_phase) begin
          w_mem_req    = 1'b1;
          w_phase_next = 1'b1;
        end else if (mem_abort) begin
          w_fault    = 1'b1;
          next_state = DONE;
        end else if (mem_ready) begin
          w_l1_cap = 1'b1;
          case (mem_rdata[1:0])
            2'b10: begin
              w_fill     = 1'b1;
              w_fill_sec = 1'b1;
              w_fill_dom = mem_rdata[5];
              w_fill_ap  = mem_rdata[11:10];
              if (perm_fault(mem_rdata[5], mem_rdata[11:10], r_write, domain_access)) begin
                w_fault    = 1'b1;
                next_state = DONE;
              end else begin
                w_load_pa  = 1'b1;
                w_next_pa  = {mem_rdata[31:20], r_va[19:0]};
                next_state = MEM_ACCESS;
              end
            end
            2'b01:   next_state = L2_FETCH;
            default: begin
              w_fault    = 1'b1;
              next_state = DONE;
            end
          endcase
        end else begin
          w_phase_next = 1'b1;
        end
      end
      L2_FETCH: begin
        w_mem_addr = w_l2_addr;
        if (!r_phase) begin
          w_mem_req    = 1'b1;
          w_phase_next = 1'b1;
        end else if (mem_abort) begin
          w_fault    = 1'b1;
          next_state = DONE;
        end else if (mem_ready) begin
          w_l2_cap = 1'b1;
          if (mem_rdata[1:0] == 2'b10) begin
            w_fill     = 1'b1;
            w_fill_dom = r_l1_pte[5];
            w_fill_ap  = mem_rdata[5:4];
            if (perm_fault(r_l1_pte[5], mem_rdata[5:4], r_write, domain_access)) begin
              w_fault    = 1'b1;
              next_state = DONE;
            end else begin
              w_load_pa  = 1'b1;
              w_next_pa  = {mem_rdata[31:12], r_va[11:0]};
              next_state = MEM_ACCESS;
            end
          end else begin
            w_fault    = 1'b1;
            next_state = DONE;
          end
        end else begin
          w_phase_next = 1'b1;
        end
      end
      MEM_ACCESS: begin
        if (!r_phase) begin
          w_mem_req    = 1'b1;
          w_mem_write  = r_write;
          w_mem_size   = r_size;
          w_phase_next = 1'b1;
        end else if (mem_ready || mem_abort) begin
          w_acc_done = 1'b1;
          next_state = DONE;
        end else begin
          w_phase_next = 1'b1;
        end
      end
      DONE: begin
        if (!cpu_req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control, status and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_cpu_abort <= 1'b0;
      r_cpu_rdata <= '0;
      r_hits      <= '0;
      r_misses    <= '0;
      r_faults    <= '0;
      r_asid_sw   <= '0;
      r_prev_asid <= '0;
    end else begin
      r_phase     <= w_phase_next;
      r_prev_asid <= current_asid;
      if (current_asid != r_prev_asid) r_asid_sw <= r_asid_sw + 32'd1;
      if (w_cnt_hit)  r_hits   <= r_hits + 32'd1;
      if (w_cnt_miss) r_misses <= r_misses + 32'd1;
      if (w_fault) begin
        r_faults    <= r_faults + 32'd1;
        r_cpu_abort <= 1'b1;
      end
      if (w_acc_done) begin
        if (mem_abort) r_cpu_abort <= 1'b1;
        else           r_cpu_ready <= 1'b1;
        if (!r_write && !mem_abort) r_cpu_rdata <= mem_rdata;
      end
      if (state == DONE && !cpu_req) begin
        r_cpu_ready <= 1'b0;
        r_cpu_abort <= 1'b0;
      end
    end
  end

  // TLB valid bits and replacement pointer; a fill coinciding with any flush is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) r_tlb_valid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        if (w_kill[i])                             r_tlb_valid[i] <= 1'b0;
        else if (w_fill_ok && r_rr == IDX_W'(i))   r_tlb_valid[i] <= 1'b1;
      end
      if (w_fill_ok) r_rr <= (r_rr == IDX_W'(TLB_ENTRIES - 1)) ? '0 : r_rr + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_ok) begin
      r_tlb_global[r_rr] <= (current_asid == 8'd0);
      r_tlb_sec[r_rr]    <= w_fill_sec;
      r_tlb_asid[r_rr]   <= current_asid;
      r_tlb_tag[r_rr]    <= r_va[31:12];
      r_tlb_pbase[r_rr]  <= mem_rdata[31:12];
      r_tlb_dom[r_rr]    <= w_fill_dom;
      r_tlb_ap[r_rr]     <= w_fill_ap;
    end
  end

  // Request latch and walk registers
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) begin
      r_va    <= cpu_vaddr;
      r_write <= cpu_write;
      r_size  <= cpu_size;
      r_wdata <= cpu_wdata;
    end
    if (w_load_pa) r_pa <= w_next_pa;
    if (w_mem_req) r_paddr_hold <= w_mem_addr;
    if (state == L1_FETCH && !r_phase) r_l1_addr <= w_l1_addr;
    if (state == L2_FETCH && !r_phase) r_l2_addr <= w_l2_addr;
    if (w_l1_cap) r_l1_pte <= mem_rdata;
    if (w_l2_cap) r_l2_pte <= mem_rdata;
  end

  assign cpu_rdata     = r_cpu_rdata;
  assign cpu_ready     = r_cpu_ready;
  assign cpu_abort     = r_cpu_abort;
  assign mem_paddr     = w_mem_req ? w_mem_addr : r_paddr_hold;
  assign mem_req       = w_mem_req;
  assign mem_write     = w_mem_write;
  assign mem_size      = w_mem_size;
  assign mem_wdata     = r_wdata;
  assign tlb_hits      = r_hits;
  assign tlb_misses    = r_misses;
  assign page_faults   = r_faults;
  assign asid_switches = r_asid_sw;
  assign mmu_busy      = (state != IDLE);

  assign w_unused = ^{cache_enable, ttb_base[13:0], tlb_flush_addr[11:0], r_l1_addr, r_l2_addr,
                      r_l2_pte, r_l1_pte[9:6], r_l1_pte[4:0]};
endmodule

// File: tb/tb_arm7tdmi_mmu.sv
// Scoreboarded bench for arm7tdmi_mmu with a word-addressed memory model holding the page tables.
module tb_arm7tdmi_mmu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_vaddr, cpu_wdata, cpu_rdata;
  logic        cpu_req, cpu_write, cpu_ready, cpu_abort;
  logic [1:0]  cpu_size, mem_size;
  logic [31:0] mem_paddr, mem_wdata, mem_rdata;
  logic        mem_req, mem_write, mem_ready, mem_abort;
  logic [31:0] ttb_base;
  logic        mmu_enable, cache_enable;
  logic [3:0]  domain_access;
  logic [7:0]  current_asid, tlb_flush_asid_val;
  logic        tlb_flush_all, tlb_flush_entry, tlb_flush_asid, tlb_flush_global;
  logic [31:0] tlb_flush_addr;
  logic [31:0] tlb_hits, tlb_misses, page_faults, asid_switches;
  logic        mmu_busy;

  int checks = 0;
  int errors = 0;
  int unsigned req_cnt = 0;

  typedef struct {
    logic        abort;
    logic [31:0] rdata;
    logic        chk_data;
    int unsigned reqs;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  arm7tdmi_mmu #(.TLB_ENTRIES(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_vaddr(cpu_vaddr), .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_abort(cpu_abort),
    .mem_paddr(mem_paddr), .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_abort(mem_abort),
    .ttb_base(ttb_base), .mmu_enable(mmu_enable), .cache_enable(cache_enable),
    .domain_access(domain_access), .current_asid(current_asid),
    .tlb_flush_all(tlb_flush_all), .tlb_flush_entry(tlb_flush_entry),
    .tlb_flush_addr(tlb_flush_addr), .tlb_flush_asid(tlb_flush_asid),
    .tlb_flush_asid_val(tlb_flush_asid_val), .tlb_flush_global(tlb_flush_global),
    .tlb_hits(tlb_hits), .tlb_misses(tlb_misses), .page_faults(page_faults),
    .asid_switches(asid_switches), .mmu_busy(mmu_busy)
  );

  // Memory answers one cycle after each request; absent words read as zero.
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_req) begin
      req_cnt <= req_cnt + 1;
      if (mem_write) mem[mem_paddr] = mem_wdata;
      else           mem_rdata <= mem.exists(mem_paddr) ? mem[mem_paddr] : 32'h0;
      mem_ready <= 1'b1;
    end
  end

  task automatic access(input string name, input logic [31:0] va, input logic wr,
                        input logic [31:0] wd, input logic exp_abort,
                        input logic [31:0] exp_rd, input int unsigned exp_reqs,
                        input int hold);
    exp_t e;
    int unsigned start;
    int cyc;
    logic rdy_seen, abt_seen;
    e.abort = exp_abort; e.rdata = exp_rd; e.chk_data = !wr && !exp_abort; e.reqs = exp_reqs;
    sb.push_back(e);
    start     = req_cnt;
    cpu_vaddr = va; cpu_write = wr; cpu_wdata = wd; cpu_size = 2'b10; cpu_req = 1'b1;
    cyc = 0;
    while (!(cpu_ready || cpu_abort) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL %s timeout: no ready/abort after %0d cycles (required within 200)", name, cyc);
    end else begin
      checks++;
      if (cpu_abort !== e.abort || cpu_ready !== !e.abort) begin
        errors++;
        $display("FAIL %s status: ready=%b abort=%b, required ready=%b abort=%b",
                 name, cpu_ready, cpu_abort, !e.abort, e.abort);
      end
      if (e.chk_data) begin
        checks++;
        if (cpu_rdata !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata: got %h, required %h", name, cpu_rdata, e.rdata);
        end
      end
      checks++;
      if (req_cnt - start != e.reqs) begin
        errors++;
        $display("FAIL %s mem_req count: got %0d, required %0d", name, req_cnt - start, e.reqs);
      end
      rdy_seen = cpu_ready; abt_seen = cpu_abort;
      for (int k = 0; k < hold; k++) @(negedge clk);
      checks++;
      if (cpu_ready !== rdy_seen || cpu_abort !== abt_seen) begin
        errors++;
        $display("FAIL %s hold: ready=%b abort=%b, required ready=%b abort=%b",
                 name, cpu_ready, cpu_abort, rdy_seen, abt_seen);
      end
    end
    cpu_req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (mmu_busy && cyc < 20);
    checks++;
    if (mmu_busy !== 1'b0 || cpu_ready !== 1'b0 || cpu_abort !== 1'b0) begin
      errors++;
      $display("FAIL %s release: busy=%b ready=%b abort=%b, required all 0",
               name, mmu_busy, cpu_ready, cpu_abort);
    end
  endtask

  task automatic check_counters(input string name, input int unsigned h, input int unsigned m,
                                input int unsigned f);
    checks++;
    if (tlb_hits !== h || tlb_misses !== m || page_faults !== f) begin
      errors++;
      $display("FAIL %s counters: hits=%0d misses=%0d faults=%0d, required %0d %0d %0d",
               name, tlb_hits, tlb_misses, page_faults, h, m, f);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0 || cpu_abort !== 1'b0 || mem_req !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b abort=%b mem_req=%b mem_write=%b, required 0000",
               cpu_ready, cpu_abort, mem_req, mem_write);
    end
    checks++;
    if (cpu_rdata !== 32'h0 || mmu_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h busy=%b, required 0 0", cpu_rdata, mmu_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_counters("reset", 0, 0, 0);
    checks++;
    if (asid_switches !== 32'd0) begin
      errors++;
      $display("FAIL reset_asid: got %0d, required 0", asid_switches);
    end
  endtask

  task automatic test_passthrough();
    mmu_enable = 1'b0;
    access("pt_read", 32'h0020_0000, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1, 1);
    checks++;
    if (mem_paddr !== 32'h0020_0000) begin
      errors++;
      $display("FAIL pt_paddr: got %h, required %h", mem_paddr, 32'h0020_0000);
    end
    check_counters("pt", 0, 0, 0);
    mmu_enable = 1'b1;
  endtask

  task automatic test_section();
    access("sec_miss", 32'h0010_0000, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1);
    check_counters("sec_miss", 0, 1, 0);
    access("sec_hit", 32'h0010_0000, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1, 1);
    check_counters("sec_hit", 1, 1, 0);
  endtask

  task automatic test_small_page();
    access("pg_rd1", 32'h0000_1000, 1'b0, 32'h0, 1'b0, 32'hCAFEBABE, 3, 1);
    access("pg_rd2", 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h12345678, 3, 1);
    access("pg_wr1", 32'h0000_1000, 1'b1, 32'hABCDEF00, 1'b0, 32'h0, 1, 1);
    checks++;
    if (mem[32'h0030_1000] !== 32'hABCDEF00) begin
      errors++;
      $display("FAIL pg_wr_mem: got %h, required %h", mem[32'h0030_1000], 32'hABCDEF00);
    end
    access("pg_rb1", 32'h0000_1000, 1'b0, 32'h0, 1'b0, 32'hABCDEF00, 1, 1);
    check_counters("pg", 3, 3, 0);
  endtask

  task automatic test_fault();
    access("xlat_fault", 32'h0000_3000, 1'b0, 32'h0, 1'b1, 32'h0, 2, 4);
    check_counters("xlat_fault", 3, 4, 1);
  endtask

  task automatic test_flush_all();
    tlb_flush_all = 1'b1;
    @(negedge clk);
    tlb_flush_all = 1'b0;
    access("fa_read", 32'h0000_1000, 1'b0, 32'h0, 1'b0, 32'hABCDEF00, 3, 1);
    check_counters("flush_all", 3, 5, 1);
  endtask

  task automatic test_flush_entry_domain();
    tlb_flush_entry = 1'b1; tlb_flush_addr = 32'h0000_1000;
    @(negedge clk);
    tlb_flush_entry = 1'b0;
    domain_access = 4'b0000;
    access("dom_fault", 32'h0000_1000, 1'b0, 32'h0, 1'b1, 32'h0, 2, 1);
    check_counters("dom_fault", 3, 6, 2);
    domain_access = 4'b0001;
    access("dom_ok1", 32'h0000_1000, 1'b0, 32'h0, 1'b0, 32'hABCDEF00, 1, 1);
    access("dom_ok2", 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h12345678, 3, 1);
    for (int v = 3; v <= 5; v++)
      access($sformatf("absent_%0d", v), 32'(v) << 12, 1'b0, 32'h0, 1'b1, 32'h0, 2, 1);
    check_counters("flush_entry", 4, 10, 5);
  endtask

  task automatic test_asid_flush();
    current_asid = 8'h05;
    @(negedge clk);
    access("asid_global_hit", 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h12345678, 1, 1);
    current_asid = 8'h00;
    @(negedge clk);
    checks++;
    if (asid_switches !== 32'd2) begin
      errors++;
      $display("FAIL asid_switches: got %0d, required 2", asid_switches);
    end
    tlb_flush_global = 1'b1;
    @(negedge clk);
    tlb_flush_global = 1'b0;
    access("after_gflush", 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h12345678, 3, 1);
    tlb_flush_asid = 1'b1; tlb_flush_asid_val = 8'h00;
    @(negedge clk);
    tlb_flush_asid = 1'b0;
    access("after_aflush", 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h12345678, 1, 1);
    check_counters("asid", 6, 11, 5);
  endtask

  task automatic test_ap();
    access("ap10_read", 32'h0000_6000, 1'b0, 32'h0, 1'b0, 32'h55AA55AA, 3, 1);
    access("ap10_write", 32'h0000_6000, 1'b1, 32'h0F0F0F0F, 1'b1, 32'h0, 0, 1);
    domain_access = 4'b0011;
    access("mgr_write", 32'h0000_6000, 1'b1, 32'h0F0F0F0F, 1'b0, 32'h0, 1, 1);
    access("mgr_read", 32'h0000_6000, 1'b0, 32'h0, 1'b0, 32'h0F0F0F0F, 1, 1);
    domain_access = 4'b0001;
    check_counters("ap", 9, 12, 6);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        access("b2b_a", 32'h0000_6000, 1'b0, 32'h0, 1'b0, 32'h0F0F0F0F, 1, 0);
      else
        access("b2b_b", 32'h0000_2000, 1'b0, 32'h0, 1'b0, 32'h12345678, 1, 0);
    end
    check_counters("b2b", 13, 12, 6);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_size = 2'b10;
    cpu_vaddr = '0; cpu_wdata = '0; mem_abort = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    ttb_base = 32'h0001_0000; mmu_enable = 1'b0; cache_enable = 1'b0;
    domain_access = 4'b0101; current_asid = 8'h00;
    tlb_flush_all = 1'b0; tlb_flush_entry = 1'b0; tlb_flush_addr = '0;
    tlb_flush_asid = 1'b0; tlb_flush_asid_val = '0; tlb_flush_global = 1'b0;
    mem[32'h0001_0000] = 32'h0001_1001;
    mem[32'h0001_0004] = 32'h0020_0C1E;
    mem[32'h0001_1004] = 32'h0030_103E;
    mem[32'h0001_1008] = 32'h0030_203E;
    mem[32'h0001_1018] = 32'h0030_602E;
    mem[32'h0020_0000] = 32'hDEADBEEF;
    mem[32'h0030_1000] = 32'hCAFEBABE;
    mem[32'h0030_2000] = 32'h12345678;
    mem[32'h0030_6000] = 32'h55AA55AA;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_section();
    test_small_page();
    test_fault();
    test_flush_all();
    test_flush_entry_domain();
    test_asid_flush();
    test_ap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
